dbg_inst_encoder: RTL and testbench

Debug-side RV32I instruction generator for the JTAG debug path. It turns abstract debug commands (write register, load, store, resume jump, raw inject) into correctly encoded 32-bit RV32I instruction words. Those words are handed one at a time over a valid/ready stream to the core's instruction-injection mux, ahead of CONTROL_UNIT decode. It is the encoding counterpart of the decode stage: every word it emits must decode there to the intended control word.

---
 rtl/dbg_inst_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_dbg_inst_encoder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_inst_encoder.sv
// dbg_inst_encoder
//
// Debug-side RV32I instruction generator. Turns abstract debug commands into
// encoded RV32I instruction words and hands them one at a time over a
// valid/ready stream to the core's instruction-injection mux.
//
// Ports:
//   clk, rst_n        single clock, synchronous active-low reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_op            0 NOP, 1 WRREG, 2 STORE, 3 LOAD, 4 JUMP, 5 RAW, 6/7 reserved
//   cmd_rd            WRREG rd, STORE rs2, LOAD rd
//   cmd_rs1           base register for STORE, LOAD, JUMP
//   cmd_data          WRREG value, STORE/LOAD offset [11:0], RAW word
//   inst_valid/ready  instruction stream handshake
//   inst_data         encoded instruction, stable while stalled
//   cmd_done          one-cycle pulse after the last word of a command is consumed
//   err, err_clr      sticky reserved-op flag and its clear
//   inst_cnt          wrapping count of consumed instructions
//
// Configuration:
//   DBG_ENC_SHORT_IMM_EN  when defined, a WRREG value that sign-extends from
//                         12 bits is emitted as a single ADDI rd,x0,lo.

module dbg_inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rs1,
  input  logic [31:0] cmd_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic        cmd_done,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] inst_cnt
);

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpWrreg = 3'd1;
  localparam logic [2:0] OpStore = 3'd2;
  localparam logic [2:0] OpLoad  = 3'd3;
  localparam logic [2:0] OpJump  = 3'd4;
  localparam logic [2:0] OpRaw   = 3'd5;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [2:0] Funct3W   = 3'b010;
  localparam logic [2:0] Funct3Add = 3'b000;

  // ADDI x0,x0,0
  localparam logic [31:0] InstNop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StEmit1, StEmit2} state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [4:0]  rd_q, rd_d;
  logic [11:0] lo_q, lo_d;
  logic        two_word_q, two_word_d;
  logic        cmd_done_q, cmd_done_d;
  logic        err_q, err_d;
  logic [15:0] inst_cnt_q, inst_cnt_d;

  logic        accept;
  logic        inst_hs;
  logic        last_hs;
  logic        reserved_op;
  logic        short_imm;
  logic [11:0] wr_lo;
  logic [19:0] wr_hi;
  logic [31:0] word1;
  logic        word1_two;

  assign cmd_ready  = (state_q == StIdle);
  assign inst_valid = (state_q != StIdle);
  assign inst_data  = inst_data_q;
  assign cmd_done   = cmd_done_q;
  assign err        = err_q;
  assign inst_cnt   = inst_cnt_q;

  assign accept      = cmd_valid & cmd_ready;
  assign inst_hs     = inst_valid & inst_ready;
  assign reserved_op = (cmd_op == 3'd6) | (cmd_op == 3'd7);

  // ADDI sign-extends lo, so hi absorbs a borrow of one whenever lo is negative.
  // The add wraps mod 2^20, which is what makes 0xFFFFF800 come out as hi=0.
  assign wr_lo = cmd_data[11:0];
  assign wr_hi = cmd_data[31:12] + {19'd0, cmd_data[11]};

`ifdef DBG_ENC_SHORT_IMM_EN
  // Value fits a signed 12-bit immediate when bits [31:11] are all equal.
  assign short_imm = (&cmd_data[31:11]) | ~(|cmd_data[31:11]);
`else
  assign short_imm = 1'b0;
`endif

  // First word of the command being presented.
  always_comb begin
    word1     = InstNop;
    word1_two = 1'b0;
    unique case (cmd_op)
      OpNop: word1 = InstNop;
      OpWrreg: begin
        if (short_imm) begin
          word1 = {wr_lo, 5'd0, Funct3Add, cmd_rd, OpcOpImm};
        end else begin
          word1     = {wr_hi, cmd_rd, OpcLui};
          word1_two = 1'b1;
        end
      end
      OpStore: word1 = {cmd_data[11:5], cmd_rd, cmd_rs1, Funct3W, cmd_data[4:0], OpcStore};
      OpLoad:  word1 = {cmd_data[11:0], cmd_rs1, Funct3W, cmd_rd, OpcLoad};
      OpJump:  word1 = {12'd0, cmd_rs1, Funct3Add, 5'd0, OpcJalr};
      OpRaw:   word1 = cmd_data;
      default: word1 = InstNop;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    inst_data_d = inst_data_q;
    rd_d        = rd_q;
    lo_d        = lo_q;
    two_word_d  = two_word_q;
    last_hs     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          inst_data_d = word1;
          rd_d        = cmd_rd;
          lo_d        = wr_lo;
          two_word_d  = word1_two;
          state_d     = StEmit1;
        end
      end
      StEmit1: begin
        if (inst_hs) begin
          if (two_word_q) begin
            // ADDI rd,rd,lo completes the LUI+ADDI pair.
            inst_data_d = {lo_q, rd_q, Funct3Add, rd_q, OpcOpImm};
            state_d     = StEmit2;
          end else begin
            last_hs = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StEmit2: begin
        if (inst_hs) begin
          last_hs = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_done_d = last_hs;
    inst_cnt_d = inst_cnt_q + {15'd0, inst_hs};
    err_d      = err_q;
    // A reserved-op acceptance beats a simultaneous clear.
    if (accept && reserved_op) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      inst_data_q <= InstNop;
      rd_q        <= 5'd0;
      lo_q        <= 12'd0;
      two_word_q  <= 1'b0;
      cmd_done_q  <= 1'b0;
      err_q       <= 1'b0;
      inst_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      inst_data_q <= inst_data_d;
      rd_q        <= rd_d;
      lo_q        <= lo_d;
      two_word_q  <= two_word_d;
      cmd_done_q  <= cmd_done_d;
      err_q       <= err_d;
      inst_cnt_q  <= inst_cnt_d;
    end
  end

endmodule

// File: tb/tb_dbg_inst_encoder.sv
// Testbench for dbg_inst_encoder: directed steps plus randomized commands,
// checked against an instruction-level reference model.

module tb_dbg_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs1;
  logic [31:0] cmd_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        cmd_done;
  logic        err;
  logic        err_clr;
  logic [15:0] inst_cnt;

  int unsigned n_pass;
  int unsigned n_total;
  logic [15:0] cnt_m;
  logic        err_m;

  dbg_inst_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_data   (cmd_data),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data),
    .cmd_done   (cmd_done),
    .err        (err),
    .err_clr    (err_clr),
    .inst_cnt   (inst_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sext12(input logic [31:0] v);
    int signed s;
    s = int'(v & 32'hFFF);
    if (s >= 2048) s = s - 4096;
    return 32'(s);
  endfunction

  // Reference model: instruction words a command must produce.
  function automatic int model_words(input logic [2:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [31:0] data,
                                     output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] imm;
    logic [31:0] hi;
    int          n;
    w0 = 32'h13;
    w1 = 32'h13;
    n  = 1;
    imm = data & 32'hFFF;
    case (op)
      3'd1: begin
`ifdef DBG_ENC_SHORT_IMM_EN
        if ($signed(data) >= -2048 && $signed(data) <= 2047) begin
          w0 = (imm << 20) | (32'(rd) << 7) | 32'h13;
          return 1;
        end
`endif
        // Round to nearest 4 KiB so the sign-extended low part adds back exactly.
        hi = (data + 32'h800) >> 12;
        w0 = (hi << 12) | (32'(rd) << 7) | 32'h37;
        w1 = (imm << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
        n  = 2;
      end
      3'd2: w0 = ((imm >> 5) << 25) | (32'(rd) << 20) | (32'(rs1) << 15) | (32'd2 << 12)
                 | ((imm & 32'h1F) << 7) | 32'h23;
      3'd3: w0 = (imm << 20) | (32'(rs1) << 15) | (32'd2 << 12) | (32'(rd) << 7) | 32'h03;
      3'd4: w0 = (32'(rs1) << 15) | 32'h67;
      3'd5: w0 = data;
      default: w0 = 32'h13;
    endcase
    return n;
  endfunction

  // Issue one command and consume its words with random stalls in [smin, smax].
  // Entered and left just after a rising edge.
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [31:0] data, input logic clr,
                         input int smin, input int smax);
    logic [31:0] e [2];
    logic [31:0] got [2];
    int          n;
    int          waited;
    int          s;
    n = model_words(op, rd, rs1, data, e[0], e[1]);
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_data  = data;
    err_clr   = clr;
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    check("inst_valid_idle", 32'(inst_valid), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    if (op >= 3'd6) err_m = 1'b1;
    else if (clr) err_m = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = $urandom_range(smax, smin);
      for (int j = 0; j < s; j++) begin
        inst_ready = 1'b0;
        // Commands offered while busy must be ignored.
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_op     = 3'd6;
        @(negedge clk);
        check("stall_valid", 32'(inst_valid), 32'd1);
        check("stall_data", inst_data, e[i]);
        check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        check("stall_cmd_done", 32'(cmd_done), 32'd0);
        @(posedge clk);
        #1;
      end
      cmd_valid  = 1'b0;
      inst_ready = 1'b1;
      @(negedge clk);
      check("word_valid", 32'(inst_valid), 32'd1);
      check("word_data", inst_data, e[i]);
      got[i] = inst_data;
      @(posedge clk);
      #1;
      inst_ready = 1'b0;
      cnt_m = cnt_m + 16'd1;
    end
    @(negedge clk);
    check("done_pulse", 32'(cmd_done), 32'd1);
    check("ready_after", 32'(cmd_ready), 32'd1);
    check("valid_after", 32'(inst_valid), 32'd0);
    check("inst_cnt", 32'(inst_cnt), 32'(cnt_m));
    check("err", 32'(err), 32'(err_m));
    if (op == 3'd1) begin
      // Execute the emitted words: the register must end up holding data.
      if (n == 2) check("wrreg_value", (got[0] & 32'hFFFF_F000) + sext12(got[1] >> 20), data);
      else check("wrreg_value", sext12(got[0] >> 20), data);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("done_single", 32'(cmd_done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] specials [6];
    logic [2:0]  op;
    logic [31:0] data;
    specials[0] = 32'hFFFF_F800;
    specials[1] = 32'h0000_0800;
    specials[2] = 32'h0000_07FF;
    specials[3] = 32'hFFFF_FFFF;
    specials[4] = 32'h0000_0000;
    specials[5] = 32'h8000_0000;
    n_pass     = 0;
    n_total    = 0;
    cnt_m      = 16'd0;
    err_m      = 1'b0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b1;
    cmd_op     = 3'd1;
    cmd_rd     = 5'd9;
    cmd_rs1    = 5'd0;
    cmd_data   = 32'h1234_5678;
    inst_ready = 1'b1;
    err_clr    = 1'b0;

    // Reset with a command presented: command discarded.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_data", inst_data, 32'h13);
    check("rst_done", 32'(cmd_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(inst_cnt), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    cmd_valid  = 1'b0;
    inst_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_valid", 32'(inst_valid), 32'd0);
    @(posedge clk);
    #1;

    // Directed commands.
    run_cmd(3'd1, 5'd5, 5'd0, 32'h1234_5678, 1'b0, 0, 0);
    run_cmd(3'd1, 5'd1, 5'd0, 32'h0000_0800, 1'b0, 0, 0);
    run_cmd(3'd1, 5'd3, 5'd0, 32'hFFFF_FFFF, 1'b0, 0, 0);
    run_cmd(3'd1, 5'd8, 5'd0, 32'hFFFF_F800, 1'b0, 0, 1);
    run_cmd(3'd2, 5'd7, 5'd2, 32'h0000_0008, 1'b0, 0, 0);
    run_cmd(3'd3, 5'd6, 5'd2, 32'h0000_0004, 1'b0, 5, 5);
    run_cmd(3'd4, 5'd0, 5'd1, 32'h0000_0000, 1'b0, 0, 0);
    run_cmd(3'd5, 5'd0, 5'd0, 32'hDEAD_BEEF, 1'b0, 0, 2);

    // Reserved ops and the sticky error flag.
    run_cmd(3'd6, 5'd0, 5'd0, 32'h0, 1'b0, 0, 0);
    run_cmd(3'd7, 5'd0, 5'd0, 32'h0, 1'b1, 0, 0);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    err_m   = 1'b0;
    @(negedge clk);
    check("err_clr_alone", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    // Randomized commands.
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      if (op >= 3'd6 && $urandom_range(0, 3) != 0) op = op - 3'd3;
      data = $urandom;
      if ($urandom_range(0, 3) == 0) data = specials[$urandom_range(0, 5)];
      else if ($urandom_range(0, 3) == 0) data = 32'($signed(12'($urandom)));
      run_cmd(op, 5'($urandom), 5'($urandom), data, 1'($urandom_range(0, 1)), 0, 3);
    end

    // Reset while the second word of a WRREG is presented.
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_rd    = 5'd4;
    cmd_data  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    inst_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    inst_ready = 1'b0;
    cnt_m      = 16'd0;
    err_m      = 1'b0;
    @(negedge clk);
    check("emit2_rst_valid", 32'(inst_valid), 32'd0);
    check("emit2_rst_data", inst_data, 32'h13);
    check("emit2_rst_cnt", 32'(inst_cnt), 32'd0);
    check("emit2_rst_done", 32'(cmd_done), 32'd0);
    check("emit2_rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("emit2_rst_done2", 32'(cmd_done), 32'd0);
    @(posedge clk);
    #1;

    // Counter wrap: preset to 0xFFFF, next handshake wraps to zero.
    force dut.inst_cnt_q = 16'hFFFF;
    #1;
    release dut.inst_cnt_q;
    cnt_m = 16'hFFFF;
    run_cmd(3'd4, 5'd0, 5'd3, 32'h0, 1'b0, 0, 0);
    check("cnt_wrapped", 32'(inst_cnt), 32'd1 - 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
